// File: rtl/multi_flex_counter_if.sv
// Bundles the per-channel control, load and terminal-value buses of multi_flex_counter.
// Channel i of every packed bus occupies slice [i*NUM_CNT_BITS +: NUM_CNT_BITS].
interface multi_flex_counter_if #(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CH       = 2
);
    logic [NUM_CH-1:0]              clear;
    logic [NUM_CH-1:0]              load;
    logic [NUM_CH*NUM_CNT_BITS-1:0] load_val;
    logic [NUM_CH-1:0]              count_enable;
    logic [NUM_CH-1:0]              count_down;
    logic [NUM_CH-1:0]              sat_mode;
    logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val;
    logic [NUM_CH*NUM_CNT_BITS-1:0] count_out;
    logic [NUM_CH-1:0]              rollover_flag;
    logic [NUM_CH-1:0]              wrap_pulse;

    modport master (
        output clear, load, load_val, count_enable, count_down, sat_mode, rollover_val,
        input  count_out, rollover_flag, wrap_pulse
    );

    modport slave (
        input  clear, load, load_val, count_enable, count_down, sat_mode, rollover_val,
        output count_out, rollover_flag, wrap_pulse
    );
endinterface

// File: rtl/multi_flex_counter.sv
// NUM_CH independent up/down counters with load, clear, wrap/saturate modes and
// optional cascading, where channel i only advances on a wrap of channel i-1.
module multi_flex_counter #(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CH       = 2,
    parameter int CASCADE      = 0
) (
    input  logic                  clk,
    input  logic                  n_rst,
    multi_flex_counter_if.slave   bus
);
    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic [NUM_CH*NUM_CNT_BITS-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]              flag_q, flag_d;
    logic [NUM_CH-1:0]              pulse_q, wrap_evt;

    always_comb begin
        logic [NUM_CNT_BITS-1:0] c, r, nxt;
        logic                    en, evt, carry;
        cnt_d    = '0;
        flag_d   = '0;
        wrap_evt = '0;
        carry    = 1'b0;
        c        = '0;
        r        = '0;
        nxt      = '0;
        en       = 1'b0;
        evt      = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            c   = cnt_q[i*NUM_CNT_BITS +: NUM_CNT_BITS];
            r   = bus.rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS];
            nxt = c;
            evt = 1'b0;
            // carry holds the previous channel's (already suppressed) wrap, so the chain ripples in one cycle
            en  = bus.count_enable[i] & ((CASCADE == 0) || (i == 0) || carry);

            if (en && (r != '0)) begin
                if (!bus.count_down[i]) begin
                    if (c < r) begin
                        nxt = c + ONE;
                    end else if (bus.sat_mode[i]) begin
                        nxt = r;
                    end else begin
                        nxt = ONE;
                        evt = 1'b1;
                    end
                end else begin
                    if (c > r) begin
                        nxt = r;
                    end else if (c > ONE) begin
                        nxt = c - ONE;
                    end else if (!bus.sat_mode[i]) begin
                        nxt = r;
                        evt = 1'b1;
                    end
                end
            end

            if (bus.clear[i]) begin
                nxt = '0;
                evt = 1'b0;
            end else if (bus.load[i]) begin
                nxt = bus.load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS];
                evt = 1'b0;
            end

            cnt_d[i*NUM_CNT_BITS +: NUM_CNT_BITS] = nxt;
            flag_d[i]   = (nxt == r);
            wrap_evt[i] = evt;
            carry       = evt;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q   <= '0;
            flag_q  <= '0;
            pulse_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            pulse_q <= wrap_evt;
        end
    end

    assign bus.count_out     = cnt_q;
    assign bus.rollover_flag = flag_q;
    assign bus.wrap_pulse    = pulse_q;
endmodule

// File: tb/tb_multi_flex_counter.sv
// Drives an independent and a cascaded 2x4-bit multi_flex_counter with the same stimulus;
// a queue of per-cycle expectations from a behavioural model is checked by a monitor.
module tb_multi_flex_counter;
    logic clk;
    logic n_rst;

    multi_flex_counter_if #(.NUM_CNT_BITS(4), .NUM_CH(2)) bus0 ();
    multi_flex_counter_if #(.NUM_CNT_BITS(4), .NUM_CH(2)) bus1 ();

    multi_flex_counter #(.NUM_CNT_BITS(4), .NUM_CH(2), .CASCADE(0)) dut0 (
        .clk(clk), .n_rst(n_rst), .bus(bus0)
    );
    multi_flex_counter #(.NUM_CNT_BITS(4), .NUM_CH(2), .CASCADE(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .bus(bus1)
    );

    typedef struct {
        logic [7:0] cnt0, cnt1;
        logic [1:0] fl0, fl1, pu0, pu1;
    } exp_t;

    exp_t sb[$];
    int   m_cnt[2][2];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for device d (0 = independent, 1 = cascaded), working on integer counts.
    function automatic void step(input int d, input logic [1:0] clr, ld, en, dn, sat,
                                 input logic [7:0] lv, rv,
                                 output logic [7:0] cnt, output logic [1:0] fl, pu);
        bit prev_wrap = 0;
        cnt = '0;
        fl  = '0;
        pu  = '0;
        for (int i = 0; i < 2; i++) begin
            int c  = m_cnt[d][i];
            int r  = int'(rv[i*4 +: 4]);
            int nx = c;
            bit w  = 0;
            bit go = en[i] && (d == 0 || i == 0 || prev_wrap);
            if (go && r != 0) begin
                if (!dn[i]) begin
                    if (c < r)       nx = c + 1;
                    else if (sat[i]) nx = r;
                    else begin nx = 1; w = 1; end
                end else begin
                    if (c > r)        nx = r;
                    else if (c > 1)   nx = c - 1;
                    else if (!sat[i]) begin nx = r; w = 1; end
                end
            end
            if (clr[i])     begin nx = 0; w = 0; end
            else if (ld[i]) begin nx = int'(lv[i*4 +: 4]); w = 0; end
            m_cnt[d][i]  = nx;
            cnt[i*4 +: 4] = 4'(nx);
            fl[i]        = (nx == r);
            pu[i]        = w;
            prev_wrap    = w;
        end
    endfunction

    task automatic cycle(input logic [1:0] clr, ld, en, dn, sat, input logic [7:0] lv, rv);
        exp_t e;
        @(negedge clk);
        n_rst = 1'b1;
        bus0.clear = clr; bus0.load = ld; bus0.count_enable = en; bus0.count_down = dn;
        bus0.sat_mode = sat; bus0.load_val = lv; bus0.rollover_val = rv;
        bus1.clear = clr; bus1.load = ld; bus1.count_enable = en; bus1.count_down = dn;
        bus1.sat_mode = sat; bus1.load_val = lv; bus1.rollover_val = rv;
        step(0, clr, ld, en, dn, sat, lv, rv, e.cnt0, e.fl0, e.pu0);
        step(1, clr, ld, en, dn, sat, lv, rv, e.cnt1, e.fl1, e.pu1);
        sb.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cnt0"},   32'(bus0.count_out),     32'd0);
        check({tag, "_flag0"},  32'(bus0.rollover_flag), 32'd0);
        check({tag, "_pulse0"}, 32'(bus0.wrap_pulse),    32'd0);
        check({tag, "_cnt1"},   32'(bus1.count_out),     32'd0);
        check({tag, "_flag1"},  32'(bus1.rollover_flag), 32'd0);
        check({tag, "_pulse1"}, 32'(bus1.wrap_pulse),    32'd0);
    endtask

    // Monitor: outputs are valid every cycle, so one expectation is consumed per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("count_out0",     32'(bus0.count_out),     32'(e.cnt0));
                check("rollover_flag0", 32'(bus0.rollover_flag), 32'(e.fl0));
                check("wrap_pulse0",    32'(bus0.wrap_pulse),    32'(e.pu0));
                check("count_out1",     32'(bus1.count_out),     32'(e.cnt1));
                check("rollover_flag1", 32'(bus1.rollover_flag), 32'(e.fl1));
                check("wrap_pulse1",    32'(bus1.wrap_pulse),    32'(e.pu1));
            end
        end
    end

    initial begin
        n_rst = 1'b0;
        bus0.clear = '0; bus0.load = '0; bus0.count_enable = '0; bus0.count_down = '0;
        bus0.sat_mode = '0; bus0.load_val = '0; bus0.rollover_val = '0;
        bus1.clear = '0; bus1.load = '0; bus1.count_enable = '0; bus1.count_down = '0;
        bus1.sat_mode = '0; bus1.load_val = '0; bus1.rollover_val = '0;
        foreach (m_cnt[d, i]) m_cnt[d][i] = 0;
        #2;
        check_all_zero("reset");

        // Up count with wrap on ch0, R=4: 1,2,3,4,1,2
        repeat (6) cycle(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 8'h00, 8'h04);
        settle();
        check("t1_ch0_final", 32'(bus0.count_out[3:0]), 32'd2);

        // Down count with wrap from load 3, R=5: 3,2,1,5,4
        cycle(2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 8'h03, 8'h05);
        repeat (4) cycle(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 8'h03, 8'h05);
        settle();
        check("t2_ch0_final", 32'(bus0.count_out[3:0]), 32'd4);

        // Saturating ch1, R=3: up 1,2,3,3,3 then down from load 2: 1,1
        repeat (5) cycle(2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 8'h00, 8'h30);
        cycle(2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 8'h20, 8'h30);
        repeat (2) cycle(2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 8'h20, 8'h30);
        settle();
        check("t3_ch1_final", 32'(bus0.count_out[7:4]), 32'd1);
        check("t3_no_pulse",  32'(bus0.wrap_pulse[1]),  32'd0);

        // Priority: clear beats load beats enable
        cycle(2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 8'h07, 8'h05);
        settle();
        check("t4_clear_wins", 32'(bus0.count_out[3:0]), 32'd0);
        cycle(2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 8'h07, 8'h05);
        cycle(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 8'h07, 8'h05);
        settle();
        check("t4_over_r_wrap", 32'(bus0.count_out[3:0]), 32'd1);
        check("t4_pulse",       32'(bus0.wrap_pulse[0]),  32'd1);

        // Cascade: R0=2, R1=3, both enabled for 8 cycles
        cycle(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h32);
        repeat (8) cycle(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 8'h32);
        settle();
        check("t5_casc_ch0", 32'(bus1.count_out[3:0]), 32'd2);
        check("t5_casc_ch1", 32'(bus1.count_out[7:4]), 32'd3);

        // Asynchronous reset between edges with ch0 at 3
        cycle(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 8'h00, 8'h09);
        settle();
        check("t6_pre_reset", 32'(bus0.count_out[3:0]), 32'd3);
        #1 n_rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        foreach (m_cnt[d, i]) m_cnt[d][i] = 0;
        cycle(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 8'h00, 8'h09);
        settle();
        check("t6_after_release", 32'(bus0.count_out[3:0]), 32'd1);

        // Random traffic; clear/load kept rare so counting sequences develop
        for (int k = 0; k < 400; k++) begin
            logic [1:0] clr, ld;
            clr = 2'($urandom_range(0, 15) == 0) | (2'($urandom_range(0, 15) == 0) << 1);
            ld  = 2'($urandom_range(0, 7) == 0)  | (2'($urandom_range(0, 7) == 0) << 1);
            cycle(clr, ld, 2'($urandom_range(0, 3)), 2'($urandom), 2'($urandom),
                  8'($urandom), 8'($urandom_range(0, 255)));
        end

        settle();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
